// File: rtl/debounce_arbiter.sv
// Debounces N noisy inputs with one shared settle counter.
// A round-robin scheduler lends the counter to one input whose synchronized level disagrees with its debounced level.
module debounce_arbiter #(
  parameter int N      = 4,
  parameter int SETTLE = 500000,
  parameter int CW     = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         noisy,
  output logic [N-1:0]         debounced,
  output logic [N-1:0]         press_pulse,
  output logic [N-1:0]         release_pulse,
  output logic                 busy,
  output logic [$clog2(N)-1:0] active_idx
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TIMING = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  mismatch;
  logic [CW-1:0] counter;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic          settle_done;

  assign mismatch    = sync2 ^ debounced;
  assign busy        = (state == TIMING) || (state == COMMIT);
  assign settle_done = (counter == CW'(SETTLE - 1));
  assign next_ptr    = (int'(active_idx) == N - 1) ? '0 : active_idx + IW'(1);

  // First mismatching input at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_found && mismatch[j]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      debounced     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      active_idx    <= '0;
      counter       <= '0;
      rr_ptr        <= '0;
      state         <= IDLE;
    end else begin
      sync1         <= noisy;
      sync2         <= sync1;
      press_pulse   <= '0;
      release_pulse <= '0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (grant_found) begin
            active_idx <= grant_idx;
            state      <= TIMING;
          end
        end
        TIMING: begin
          // A bounce back to the debounced level abandons the slot without touching outputs.
          if (!mismatch[active_idx]) begin
            rr_ptr  <= next_ptr;
            counter <= '0;
            state   <= IDLE;
          end else if (settle_done) begin
            debounced[active_idx] <= ~debounced[active_idx];
            if (debounced[active_idx]) release_pulse[active_idx] <= 1'b1;
            else                       press_pulse[active_idx]   <= 1'b1;
            counter <= '0;
            state   <= COMMIT;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        COMMIT: begin
          rr_ptr  <= next_ptr;
          counter <= '0;
          state   <= IDLE;
        end
        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Self-checking bench for debounce_arbiter: directed scenarios then random bouncing,
// compared every cycle against a deadline-based reference model.
module tb_debounce_arbiter;

  localparam int N      = 4;
  localparam int SETTLE = 8;
  localparam int CW     = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] noisy;
  logic [N-1:0] debounced;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         busy;
  logic [1:0]   active_idx;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: an owner is granted at edge grant_edge and commits exactly SETTLE edges later.
  logic [N-1:0] m_deb   = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;
  logic [N-1:0] hist[$];
  int owner      = -1;
  int grant_edge = 0;
  int edge_no    = 0;
  int ptr        = 0;
  int last_idx   = 0;

  debounce_arbiter #(.N(N), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .noisy         (noisy),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .busy          (busy),
    .active_idx    (active_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] nz, input logic rst);
    logic [N-1:0] sync_now;
    logic [N-1:0] mm;
    int d;
    bit found;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_deb    = '0;
      owner    = -1;
      last_idx = 0;
      ptr      = 0;
      edge_no  = 0;
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      return;
    end
    edge_no++;
    sync_now = hist.pop_front();
    hist.push_back(nz);
    if (owner >= 0) begin
      d = edge_no - grant_edge;
      if (d == SETTLE + 1) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end else if (sync_now[owner] == m_deb[owner]) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end else if (d == SETTLE) begin
        if (m_deb[owner]) m_rel[owner] = 1'b1;
        else              m_press[owner] = 1'b1;
        m_deb[owner] = ~m_deb[owner];
      end
    end else begin
      mm    = sync_now ^ m_deb;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && mm[(ptr + k) % N]) begin
          found      = 1'b1;
          owner      = (ptr + k) % N;
          last_idx   = owner;
          grant_edge = edge_no;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] nz, input logic rst);
    @(negedge clk);
    noisy = nz;
    reset = rst;
    @(posedge clk);
    model_step(nz, rst);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("debounced", 32'(debounced), 32'(m_deb));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_rel));
    check("busy", 32'(busy), 32'(owner >= 0));
    check("active_idx", 32'(active_idx), 32'(last_idx));
  endtask

  initial begin
    logic [N-1:0] nz;
    int t0;
    int t3;
    int rel_cnt;
    int press_cnt;
    noisy = '0;
    reset = 1'b1;

    // 1: reset then quiet inputs
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    repeat (20) applyStimulus(4'b0000, 1'b0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: clean rise on input 1
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(4'b0010, 1'b0);
      if (i == 10) check("t2_deb_before", 32'(debounced[1]), 32'd0);
      if (i == 11) check("t2_deb_at_11", 32'(debounced[1]), 32'd1);
      if (i == 11) check("t2_press_at_11", 32'(press_pulse), 32'b0010);
      if (i == 12) check("t2_press_gone", 32'(press_pulse), 32'd0);
    end

    // 3: input 2 rises then falls four cycles after its grant
    for (int i = 1; i <= 9; i++) begin
      applyStimulus((i < 7) ? 4'b0110 : 4'b0010, 1'b0);
      if (i == 3) check("t3_grant_idx", 32'(active_idx), 32'd2);
      if (i == 8) check("t3_busy_before_abort", 32'(busy), 32'd1);
    end
    check("t3_busy_after_abort", 32'(busy), 32'd0);
    check("t3_deb2_low", 32'(debounced[2]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1011, 1'b0);
      if (busy) break;
    end
    check("t3_next_grant_from_ptr3", 32'(active_idx), 32'd3);
    repeat (30) applyStimulus(4'b1011, 1'b0);

    // 5: release on input 1
    rel_cnt   = 0;
    press_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1001, 1'b0);
      if (release_pulse[1]) rel_cnt++;
      if (press_pulse != '0) press_cnt++;
    end
    check("t5_release_cycles", 32'(rel_cnt), 32'd1);
    check("t5_press_cycles", 32'(press_cnt), 32'd0);
    check("t5_deb1_low", 32'(debounced[1]), 32'd0);

    // 4: simultaneous rise on inputs 0 and 3 with the pointer at 0
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b0);
    t0 = -1;
    t3 = -1;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(4'b1001, 1'b0);
      if (t0 < 0 && debounced[0]) t0 = i;
      if (t3 < 0 && debounced[3]) t3 = i;
    end
    check("t4_first_commit", 32'(t0), 32'd11);
    check("t4_second_gap", 32'(t3 - t0), 32'd10);

    // 6: reset while timing input 2 with the counter at 5
    applyStimulus(4'b0000, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(4'b0100, 1'b0);
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_idx_pre", 32'(active_idx), 32'd2);
    applyStimulus(4'b0100, 1'b1);
    check("t6_deb_cleared", 32'(debounced), 32'd0);
    check("t6_busy_cleared", 32'(busy), 32'd0);
    check("t6_idx_cleared", 32'(active_idx), 32'd0);
    repeat (15) applyStimulus(4'b0000, 1'b0);
    check("t6_deb2_never", 32'(debounced[2]), 32'd0);

    // Random bouncing with occasional resets
    nz = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) nz = nz ^ (4'b0001 << $urandom_range(0, N - 1));
      applyStimulus(nz, ($urandom_range(0, 499) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
